// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu -- MEM-stage load/store unit of the 5-stage RISC-V core.
//
// Sits between the ex_mem and mem_wb pipeline registers. Memory ops are
// carried out over a byte-wide request/acknowledge data-memory port, one byte
// per transfer, little-endian (lowest address = least significant byte).
// Loads are sign- or zero-extended; non-memory results pass straight through.
// stall_req_o holds the front of the pipeline while an access is in progress.
//
// Optional build macro:
//   MEM_ALIGN_CHK_EN  - when defined, misaligned H/HU/SH and W/SW ops are
//                       rejected without any bus traffic and flagged on an
//                       extra misalign_o output for one cycle. When undefined,
//                       any alignment is handled byte by byte.
//
// Ports:
//   clk          core clock, rising edge
//   rst          asynchronous reset, active low
//   wd_i         destination register index from ex_mem
//   wdata_i      EX result for non-load ops
//   wreg_i       register write enable from ex_mem
//   mem_op_i     0=NONE 1=LB 2=LH 3=LW 4=LBU 5=LHU 6=SB 7=SH 8=SW, others=NONE
//   mem_addr_i   effective byte address
//   mem_sdata_i  store data
//   wd_o         destination register index to mem_wb
//   data_o       write-back data to mem_wb
//   wreg_o       register write enable to mem_wb
//   stall_req_o  freeze IF..EX and ex_mem while high
//   mem_req_o    byte transfer request
//   mem_wr_o     1=write, 0=read (valid with mem_req_o)
//   mem_a_o      byte address (valid with mem_req_o)
//   mem_dout_o   write byte (valid with mem_req_o)
//   mem_din_i    read byte, sampled on the acknowledging clock edge
//   mem_ack_i    transfer complete; ignored while mem_req_o is low
//   misalign_o   (MEM_ALIGN_CHK_EN only) misaligned access rejected this cycle
// -----------------------------------------------------------------------------
module mem_lsu #(
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic [31:0]           wdata_i,
   input  logic                  wreg_i,
   input  logic [3:0]            mem_op_i,
   input  logic [ADDR_W-1:0]     mem_addr_i,
   input  logic [31:0]           mem_sdata_i,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic [31:0]           data_o,
   output logic                  wreg_o,
   output logic                  stall_req_o,
   output logic                  mem_req_o,
   output logic                  mem_wr_o,
   output logic [ADDR_W-1:0]     mem_a_o,
   output logic [7:0]            mem_dout_o,
   input  logic [7:0]            mem_din_i,
   input  logic                  mem_ack_i
`ifdef MEM_ALIGN_CHK_EN
   ,
   output logic                  misalign_o
`endif
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_LBU = 4'd4;
   localparam logic [3:0] OP_LHU = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;

   // ---------------------------------------------------------------------
   // Op decode
   // ---------------------------------------------------------------------
   logic       is_load;
   logic       is_store;
   logic       is_mem;
   logic [1:0] last_idx;     // index of the final byte: N-1
   logic       misaligned;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      last_idx = 2'd0;
      unique case (mem_op_i)
         OP_LB, OP_LBU: begin is_load  = 1'b1; last_idx = 2'd0; end
         OP_LH, OP_LHU: begin is_load  = 1'b1; last_idx = 2'd1; end
         OP_LW:         begin is_load  = 1'b1; last_idx = 2'd3; end
         OP_SB:         begin is_store = 1'b1; last_idx = 2'd0; end
         OP_SH:         begin is_store = 1'b1; last_idx = 2'd1; end
         OP_SW:         begin is_store = 1'b1; last_idx = 2'd3; end
         default:       begin is_load  = 1'b0; is_store = 1'b0; end
      endcase
      is_mem = is_load | is_store;
   end

`ifdef MEM_ALIGN_CHK_EN
   always_comb begin
      misaligned = 1'b0;
      if (is_mem) begin
         if (last_idx == 2'd1)
            misaligned = mem_addr_i[0];
         else if (last_idx == 2'd3)
            misaligned = (mem_addr_i[1:0] != 2'b00);
      end
   end
`else
   // Without the checker every alignment is legal: bytes are fetched one at
   // a time, so crossing a word boundary needs no special handling.
   assign misaligned = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Load buffer: one register per byte lane, written when that lane's
   // transfer is acknowledged.
   // ---------------------------------------------------------------------
   logic [3:0]  lane_we;
   logic [31:0] ld_word;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] byte_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               byte_q <= 8'h00;
            else if (lane_we[gi])
               byte_q <= mem_din_i;
         end

         assign ld_word[8*gi +: 8] = byte_q;
      end
   endgenerate

   // Extended load result, consumed in DONE.
   logic [31:0] ld_ext;

   always_comb begin
      ld_ext = ld_word;
      unique case (mem_op_i)
         OP_LB:   ld_ext = {{24{ld_word[7]}},  ld_word[7:0]};
         OP_LBU:  ld_ext = {24'h000000,        ld_word[7:0]};
         OP_LH:   ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
         OP_LHU:  ld_ext = {16'h0000,          ld_word[15:0]};
         default: ld_ext = ld_word;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and outputs (before reset gating)
   // ---------------------------------------------------------------------
   logic [REG_ADDR_W-1:0] wd_c;
   logic [31:0]           data_c;
   logic                  wreg_c;
   logic                  stall_c;
   logic                  req_c;
   logic                  wr_c;
   logic [ADDR_W-1:0]     addr_c;
   logic [7:0]            dout_c;
   logic                  mis_c;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lane_we = 4'b0000;
      wd_c    = wd_i;
      data_c  = wdata_i;
      wreg_c  = wreg_i;
      stall_c = 1'b0;
      req_c   = 1'b0;
      wr_c    = 1'b0;
      addr_c  = '0;
      dout_c  = 8'h00;
      mis_c   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (is_mem) begin
               if (misaligned) begin
                  // Rejected in place: the pipeline moves on next cycle.
                  mis_c  = 1'b1;
                  wreg_c = 1'b0;
               end else begin
                  stall_c = 1'b1;
                  wreg_c  = 1'b0;
                  data_c  = 32'h0;
                  state_d = ST_ACCESS;
                  cnt_d   = 2'd0;
               end
            end
         end

         ST_ACCESS: begin
            // Request fields depend only on held inputs and cnt_q, so they
            // stay stable for as long as the memory keeps ack low.
            stall_c = 1'b1;
            wreg_c  = 1'b0;
            data_c  = 32'h0;
            req_c   = 1'b1;
            wr_c    = is_store;
            addr_c  = mem_addr_i + ADDR_W'(cnt_q);
            dout_c  = mem_sdata_i[8*cnt_q +: 8];
            if (mem_ack_i) begin
               if (is_load)
                  lane_we[cnt_q] = 1'b1;
               if (cnt_q == last_idx) begin
                  state_d = ST_DONE;
                  cnt_d   = 2'd0;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end

         ST_DONE: begin
            // One-cycle result slot; always back to IDLE so the held op
            // cannot start a second time.
            state_d = ST_IDLE;
            if (is_load)
               data_c = ld_ext;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs are forced to zero for as long as reset is held, including
   // the otherwise combinational pass-through path.
   // ---------------------------------------------------------------------
   assign wd_o        = rst ? wd_c    : '0;
   assign data_o      = rst ? data_c  : 32'h0;
   assign wreg_o      = rst ? wreg_c  : 1'b0;
   assign stall_req_o = rst ? stall_c : 1'b0;
   assign mem_req_o   = rst ? req_c   : 1'b0;
   assign mem_wr_o    = rst ? wr_c    : 1'b0;
   assign mem_a_o     = rst ? addr_c  : '0;
   assign mem_dout_o  = rst ? dout_c  : 8'h00;

`ifdef MEM_ALIGN_CHK_EN
   assign misalign_o  = rst ? mis_c   : 1'b0;
`else
   // mis_c is never set when the checker is absent.
   logic unused_mis;
   assign unused_mis = mis_c;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu -- self-checking bench for mem_lsu.
// A byte-addressed memory responder with configurable ack wait states (and
// random ignored acks while no request is pending) serves the DUT. A separate
// model memory plus arithmetic load/store rules give the expected results.
// -----------------------------------------------------------------------------
module tb_mem_lsu;

   localparam int AW = 32;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic [RW-1:0] wd_i;
   logic [31:0]   wdata_i;
   logic          wreg_i;
   logic [3:0]    mem_op_i;
   logic [AW-1:0] mem_addr_i;
   logic [31:0]   mem_sdata_i;
   logic [RW-1:0] wd_o;
   logic [31:0]   data_o;
   logic          wreg_o;
   logic          stall_req_o;
   logic          mem_req_o;
   logic          mem_wr_o;
   logic [AW-1:0] mem_a_o;
   logic [7:0]    mem_dout_o;
   logic [7:0]    mem_din_i = 8'h00;
   logic          mem_ack_i = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
   logic          misalign_o;
`endif

   mem_lsu #(.ADDR_W(AW), .REG_ADDR_W(RW)) dut (
      .clk         (clk),
      .rst         (rst),
      .wd_i        (wd_i),
      .wdata_i     (wdata_i),
      .wreg_i      (wreg_i),
      .mem_op_i    (mem_op_i),
      .mem_addr_i  (mem_addr_i),
      .mem_sdata_i (mem_sdata_i),
      .wd_o        (wd_o),
      .data_o      (data_o),
      .wreg_o      (wreg_o),
      .stall_req_o (stall_req_o),
      .mem_req_o   (mem_req_o),
      .mem_wr_o    (mem_wr_o),
      .mem_a_o     (mem_a_o),
      .mem_dout_o  (mem_dout_o),
      .mem_din_i   (mem_din_i),
      .mem_ack_i   (mem_ack_i)
`ifdef MEM_ALIGN_CHK_EN
      ,
      .misalign_o  (misalign_o)
`endif
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Memories, bus log, counters
   // ---------------------------------------------------------------------
   logic [7:0] bus_mem   [0:1023];
   logic [7:0] model_mem [0:1023];

   typedef struct packed {
      logic        wr;
      logic [31:0] a;
      logic [7:0]  d;
   } xfer_t;
   xfer_t bus_log[$];

   int wait_cfg    = 0;
   int waits_left  = -1;
   bit spur_en     = 1'b1;
   int n_checks    = 0;
   int n_fails     = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Memory responder: decisions made on the falling edge, seen by the DUT
   // on the next rising edge.
   // ---------------------------------------------------------------------
   always @(negedge clk) begin
      if (mem_ack_i) begin
         mem_ack_i  = 1'b0;
         waits_left = -1;
      end
      if (mem_req_o) begin
         if (waits_left < 0)
            waits_left = wait_cfg;
         if (waits_left == 0) begin
            mem_ack_i = 1'b1;
            if (mem_wr_o)
               bus_mem[mem_a_o[9:0]] = mem_dout_o;
            else
               mem_din_i = bus_mem[mem_a_o[9:0]];
            bus_log.push_back({mem_wr_o, mem_a_o,
                               mem_wr_o ? mem_dout_o : bus_mem[mem_a_o[9:0]]});
            waits_left = -1;
         end else begin
            waits_left--;
         end
      end else begin
         waits_left = -1;
         mem_ack_i  = spur_en && ($urandom_range(0, 3) == 0);
         mem_din_i  = 8'($urandom);
      end
   end

   // ---------------------------------------------------------------------
   // Reference rules
   // ---------------------------------------------------------------------
   function automatic int nbytes(input logic [3:0] op);
      case (op)
         4'd1, 4'd4, 4'd6: return 1;
         4'd2, 4'd5, 4'd7: return 2;
         4'd3, 4'd8:       return 4;
         default:          return 0;
      endcase
   endfunction

   function automatic bit op_is_store(input logic [3:0] op);
      return (op >= 4'd6) && (op <= 4'd8);
   endfunction

   function automatic bit op_is_mis(input logic [3:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHK_EN
      int n = nbytes(op);
      return (n == 2 && (addr % 2) != 0) || (n == 4 && (addr % 4) != 0);
`else
      return (op == 4'd0) && (addr == 32'h1) && 1'b0;
`endif
   endfunction

   // Little-endian value of N model bytes, then signed or unsigned by op.
   function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] addr);
      longint v = 0;
      longint scale = 1;
      int n = nbytes(op);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = addr + 32'(i);
         v += longint'(model_mem[a[9:0]]) * scale;
         scale *= 256;
      end
      if ((op == 4'd1 || op == 4'd2) && v >= scale / 2)
         v -= scale;
      return v[31:0];
   endfunction

   // ---------------------------------------------------------------------
   // One pipeline transaction: drive, wait for the stall to end, check.
   // ---------------------------------------------------------------------
   task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] wdata, input logic [RW-1:0] wd, input logic wreg,
                         input int wt);
      int          n       = nbytes(op);
      bit          st      = op_is_store(op);
      bit          mis     = op_is_mis(op, addr);
      int          exp_stall;
      int          exp_xfers;
      int          stall_cnt = 0;
      bit          done    = 1'b0;
      logic [31:0] exp_data;
      logic [31:0] a;
      xfer_t       ex;

      exp_stall = (n > 0 && !mis) ? 1 + n * (1 + wt) : 0;
      exp_xfers = (n > 0 && !mis) ? n : 0;
      exp_data  = (n > 0 && !st) ? exp_load(op, addr) : wdata;

      wait_cfg = wt;
      bus_log.delete();
      @(posedge clk);
      #1;
      mem_op_i    = op;
      mem_addr_i  = addr;
      mem_sdata_i = sdata;
      wdata_i     = wdata;
      wd_i        = wd;
      wreg_i      = wreg;

      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (!stall_req_o) begin
            done = 1'b1;
            break;
         end
         stall_cnt++;
      end

      check("timeout", 64'(done), 64'd1);
      check("stall_cycles", 64'(stall_cnt), 64'(exp_stall));
      check("req_at_result", 64'(mem_req_o), 64'd0);
      check("wreg_o", 64'(wreg_o), 64'(mis ? 1'b0 : wreg));
      if (!mis) begin
         check("wd_o", 64'(wd_o), 64'(wd));
         check("data_o", 64'(data_o), 64'(exp_data));
      end
`ifdef MEM_ALIGN_CHK_EN
      check("misalign_o", 64'(misalign_o), 64'(mis));
`endif
      check("xfer_count", 64'(bus_log.size()), 64'(exp_xfers));
      for (int i = 0; i < exp_xfers && i < bus_log.size(); i++) begin
         a  = addr + 32'(i);
         ex = {st, a, st ? sdata[8*i +: 8] : model_mem[a[9:0]]};
         check("xfer", 64'(bus_log[i]), 64'(ex));
      end
      if (st && !mis) begin
         for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            model_mem[a[9:0]] = sdata[8*i +: 8];
         end
      end
      $display("op=%0d addr=%08h wait=%0d stall=%0d xfers=%0d data_o=%08h wreg_o=%0d",
               op, addr, wt, stall_cnt, bus_log.size(), data_o, wreg_o);
   endtask

   // ---------------------------------------------------------------------
   // Directed and random sequence
   // ---------------------------------------------------------------------
   initial begin
      logic [7:0]  b;
      logic [3:0]  rop;
      logic [31:0] raddr;
      bit          found = 1'b0;

      for (int i = 0; i < 1024; i++) begin
         b = 8'($urandom);
         bus_mem[i]   = b;
         model_mem[i] = b;
      end
      bus_mem[10'h100] = 8'h80;  model_mem[10'h100] = 8'h80;
      bus_mem[10'h010] = 8'h34;  model_mem[10'h010] = 8'h34;
      bus_mem[10'h011] = 8'h12;  model_mem[10'h011] = 8'h12;

      // Reset: all outputs zero even with a pass-through op presented.
      rst = 1'b0;
      mem_op_i = 4'd0; mem_addr_i = '0; mem_sdata_i = '0;
      wdata_i = 32'hDEAD_BEEF; wd_i = 5'd3; wreg_i = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_wd_o", 64'(wd_o), 64'd0);
      check("rst_data_o", 64'(data_o), 64'd0);
      check("rst_wreg_o", 64'(wreg_o), 64'd0);
      check("rst_stall", 64'(stall_req_o), 64'd0);
      check("rst_req", 64'(mem_req_o), 64'd0);
      rst = 1'b1;

      // Directed cases.
      run_op(4'd0, 32'h0,   32'h0,         32'h0000_1234, 5'd5,  1'b1, 0);
      run_op(4'd1, 32'h100, 32'h0,         32'h0,         5'd6,  1'b1, 0);
      run_op(4'd4, 32'h100, 32'h0,         32'h0,         5'd7,  1'b1, 0);
      run_op(4'd8, 32'h200, 32'h1122_3344, 32'h0000_0200, 5'd0,  1'b0, 0);
      run_op(4'd3, 32'h200, 32'h0,         32'h0,         5'd8,  1'b1, 1);
      run_op(4'd2, 32'h10,  32'h0,         32'h0,         5'd9,  1'b1, 2);
      run_op(4'd3, 32'h102, 32'h0,         32'h0,         5'd10, 1'b1, 0);
      run_op(4'd7, 32'h3FF, 32'hABCD_8E7F, 32'h5,         5'd11, 1'b0, 1);
      run_op(4'd3, 32'hFFFF_FFFE, 32'h0,   32'h0,         5'd12, 1'b1, 0);
      run_op(4'd5, 32'h3FF, 32'h0,         32'h0,         5'd13, 1'b1, 3);

      // Reset in the middle of the third byte of an LW.
      wait_cfg = 3;
      bus_log.delete();
      @(posedge clk);
      #1;
      mem_op_i = 4'd3; mem_addr_i = 32'h300; wd_i = 5'd14; wreg_i = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (bus_log.size() == 2 && mem_req_o) begin
            found = 1'b1;
            break;
         end
      end
      check("rst_reach_byte3", 64'(found), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check("midrst_req", 64'(mem_req_o), 64'd0);
      check("midrst_stall", 64'(stall_req_o), 64'd0);
      check("midrst_wreg", 64'(wreg_o), 64'd0);
      check("midrst_data", 64'(data_o), 64'd0);
      check("midrst_wd", 64'(wd_o), 64'd0);
      mem_op_i = 4'd0; wd_i = 5'd7; wdata_i = 32'h0000_CAFE; wreg_i = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("postrst_wd", 64'(wd_o), 64'd7);
      check("postrst_data", 64'(data_o), 64'h0000_CAFE);
      check("postrst_stall", 64'(stall_req_o), 64'd0);
      $display("op=3 addr=00000300 reset after 2 bytes, pass-through resumed");
      run_op(4'd3, 32'h300, 32'h0, 32'h0, 5'd15, 1'b1, 0);

      // Random ops.
      for (int k = 0; k < 60; k++) begin
         rop   = 4'($urandom_range(0, 15));
         raddr = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 1) == 1)
            raddr = raddr & 32'hFFFF_FFFC;
         run_op(rop, raddr, $urandom, $urandom, 5'($urandom), 1'($urandom),
                $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
